// File: rtl/stream_mux_pkg.sv
// Shared types, constants and the round-robin search helper for stream_mux_rr.
package stream_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Width of each per-channel packet counter.
  localparam int CNT_W = 16;

  // Largest channel count the round-robin helper can search.
  localparam int MAX_CH = 32;

  // First requesting index strictly after ptr, wrapping modulo n_ch.
  // Returns ptr when nothing is requesting.
  function automatic int unsigned rr_next(input logic [MAX_CH-1:0] req,
                                          input int unsigned ptr,
                                          input int unsigned n_ch);
    int unsigned idx;
    logic        found;
    rr_next = ptr;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      if ((k <= n_ch) && !found) begin
        idx = (ptr + k) % n_ch;
        if (req[idx]) begin
          rr_next = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational round-robin arbiter; the pointer register lives in the parent.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [MAX_CH-1:0] req_ext;

  // Search from ptr+1 upward for the first active request.
  always_comb begin
    req_ext            = '0;
    req_ext[N_CH-1:0]  = req;
    gnt_idx            = SEL_W'(rr_next(req_ext, 32'(ptr), N_CH));
    gnt_vld            = |req;
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel packet-locked stream mux with registered output stage.
// Channel choice: external sel (ARB_MODE=0) or round-robin (ARB_MODE=1).
// Optional per-channel packet counters: define STREAM_MUX_PKT_CNT_EN.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int N_CH     = 4,
  parameter int ARB_MODE = 0,
  parameter int SEL_W    = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready
`ifdef STREAM_MUX_PKT_CNT_EN
  ,
  output logic [N_CH*CNT_W-1:0] pkt_cnt
`endif
);

  state_e           state_reg, state_next;
  logic [SEL_W-1:0] locked_ch_reg;
  logic [SEL_W-1:0] rr_ptr_reg;

  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load_ok;
  logic             xfer;
  logic             grant_last;
  logic [WIDTH-1:0] grant_data;

  logic [SEL_W-1:0] arb_idx;
  logic             arb_vld;

  logic [WIDTH-1:0] ch_data [N_CH];

  genvar gi;

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_slice
      assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      // At most one ready bit: only the granted channel can see it.
      assign in_ready[gi] = xfer && (grant == SEL_W'(gi));
    end
  endgenerate

  rr_arbiter #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .req     (in_valid),
    .ptr     (rr_ptr_reg),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Grant selection: locked channel wins, otherwise sel or the arbiter.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    if (state_reg == LOCKED) begin
      grant       = locked_ch_reg;
      grant_valid = in_valid[locked_ch_reg];
    end else if (ARB_MODE == 1) begin
      grant       = arb_idx;
      grant_valid = arb_vld;
    end else begin
      grant       = sel;
      grant_valid = in_valid[sel];
    end
  end

  // Handshake: the granted beat moves when the output register can take it.
  // rst_n gating keeps every in_ready low while reset is held.
  always_comb begin
    load_ok    = !out_valid || out_ready;
    xfer       = grant_valid && load_ok && rst_n;
    grant_last = in_last[grant];
    grant_data = ch_data[grant];
  end

  // Next-state: lock on a non-last first beat, unlock on the last beat.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (xfer && !grant_last) state_next = LOCKED;
      LOCKED:  if (xfer && grant_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, lock owner and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      locked_ch_reg <= '0;
      rr_ptr_reg    <= SEL_W'(N_CH - 1);
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && xfer && !grant_last) begin
        locked_ch_reg <= grant;
      end
      if (xfer && grant_last) begin
        rr_ptr_reg <= grant;
      end
    end
  end

  // Output register: load on transfer, drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_data  <= grant_data;
      out_valid <= 1'b1;
      out_last  <= grant_last;
      out_ch    <= grant;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef STREAM_MUX_PKT_CNT_EN
  logic [CNT_W-1:0] cnt_reg [N_CH];

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_cnt
      // Count packets as their last beat is accepted; wraps naturally.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg[gi] <= '0;
        end else if (in_ready[gi] && in_last[gi]) begin
          cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
        end
      end
      assign pkt_cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: one instance per arbitration mode, a reference
// model of the handshake rules checked every cycle, plus literal checks.
module tb_stream_mux_rr;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] in_data_s   [2];
  logic [N-1:0]   in_valid_s  [2];
  logic [N-1:0]   in_last_s   [2];
  logic [N-1:0]   in_ready_s  [2];
  logic [S-1:0]   sel_s       [2];
  logic [W-1:0]   out_data_s  [2];
  logic           out_valid_s [2];
  logic           out_last_s  [2];
  logic [S-1:0]   out_ch_s    [2];
  logic           out_ready_s [2];
`ifdef STREAM_MUX_PKT_CNT_EN
  logic [N*16-1:0] pkt_cnt_s  [2];
`endif

  int checks = 0;
  int errors = 0;
  bit quiet  = 1'b0;

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(W), .N_CH(N), .ARB_MODE(0)) u_sel (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data_s[0]), .in_valid(in_valid_s[0]), .in_last(in_last_s[0]),
    .in_ready(in_ready_s[0]), .sel(sel_s[0]),
    .out_data(out_data_s[0]), .out_valid(out_valid_s[0]), .out_last(out_last_s[0]),
    .out_ch(out_ch_s[0]), .out_ready(out_ready_s[0])
`ifdef STREAM_MUX_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt_s[0])
`endif
  );

  stream_mux_rr #(.WIDTH(W), .N_CH(N), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data_s[1]), .in_valid(in_valid_s[1]), .in_last(in_last_s[1]),
    .in_ready(in_ready_s[1]), .sel(sel_s[1]),
    .out_data(out_data_s[1]), .out_valid(out_valid_s[1]), .out_last(out_last_s[1]),
    .out_ch(out_ch_s[1]), .out_ready(out_ready_s[1])
`ifdef STREAM_MUX_PKT_CNT_EN
    , .pkt_cnt(pkt_cnt_s[1])
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: which channel owns the output (-1 = none), who was served
  // last, and what the output register must hold.
  int       m_lock [2];
  int       m_ptr  [2];
  bit       m_ov   [2];
  bit       m_ol   [2];
  int       m_och  [2];
  logic [7:0] m_od [2];

  // Channel that must be served this cycle, or -1 if none has a beat.
  function automatic int m_grant(int d);
    int idx;
    if (m_lock[d] >= 0) return in_valid_s[d][m_lock[d]] ? m_lock[d] : -1;
    if (d == 0) return in_valid_s[d][sel_s[d]] ? int'(sel_s[d]) : -1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_ptr[d] + k) % N;
      if (in_valid_s[d][idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit m_moves(int d);
    return (m_grant(d) >= 0) && (!m_ov[d] || out_ready_s[d]) && (rst_n === 1'b1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_lock[d] = -1; m_ptr[d] = N - 1; m_ov[d] = 0; m_ol[d] = 0;
        m_och[d] = 0;   m_od[d] = 8'h00;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        int g;
        g = m_grant(d);
        if (m_moves(d)) begin
          m_ov[d]  = 1;
          m_od[d]  = in_data_s[d][g*W +: W];
          m_ol[d]  = in_last_s[d][g];
          m_och[d] = g;
          if (in_last_s[d][g]) begin
            m_lock[d] = -1;
            m_ptr[d]  = g;
          end else begin
            m_lock[d] = g;
          end
        end else if (out_ready_s[d]) begin
          m_ov[d] = 0;
        end
      end
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic [3:0] one;
      logic [3:0] exp_rdy;
      one     = 4'b0001;
      exp_rdy = m_moves(d) ? (one << m_grant(d)) : 4'b0000;
      chk($sformatf("m%0d_in_ready", d), 64'(in_ready_s[d]), 64'(exp_rdy));
      chk($sformatf("m%0d_out_valid", d), 64'(out_valid_s[d]), 64'(m_ov[d]));
      if (m_ov[d]) begin
        chk($sformatf("m%0d_out_data", d), 64'(out_data_s[d]), 64'(m_od[d]));
        chk($sformatf("m%0d_out_last", d), 64'(out_last_s[d]), 64'(m_ol[d]));
        chk($sformatf("m%0d_out_ch", d), 64'(out_ch_s[d]), 64'(m_och[d]));
        if (out_ready_s[d] && !quiet)
          $display("beat dut%0d ch=%0d data=%02h last=%0b", d, out_ch_s[d], out_data_s[d], out_last_s[d]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(int d, int ch, logic [7:0] v);
    in_data_s[d][ch*W +: W] = v;
  endtask

  int rr_seq [5];
  int rr_exp [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_data_s[d] = '0; in_valid_s[d] = '0; in_last_s[d] = '0;
      sel_s[d] = '0; out_ready_s[d] = 1'b1;
    end
    #1;
    chk("rst_in_ready", 64'(in_ready_s[0]), 64'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_s[0]), 64'h0);
    chk("rst_out_data", 64'(out_data_s[1]), 64'h0);

    // Round robin from reset: single-beat packets on every channel.
    step();
    in_valid_s[1] = 4'b1111; in_last_s[1] = 4'b1111;
    for (int i = 0; i < N; i++) set_ch(1, i, 8'(8'hC0 + i));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      rr_seq[i] = int'(out_ch_s[1]);
      chk("rr_throughput_valid", 64'(out_valid_s[1]), 64'h1);
    end
    for (int i = 0; i < 5; i++) chk($sformatf("rr_seq%0d", i), 64'(rr_seq[i]), 64'(rr_exp[i]));
    step();
    in_valid_s[1] = '0;

    // External select, single beat on ch2.
    sel_s[0] = 2'd2; in_valid_s[0] = 4'b0100; in_last_s[0] = 4'b0100; set_ch(0, 2, 8'hAA);
    @(negedge clk);
    chk("t1_in_ready", 64'(in_ready_s[0]), 64'h4);
    step();
    in_valid_s[0] = '0;
    @(negedge clk);
    chk("t1_out_data", 64'(out_data_s[0]), 64'hAA);
    chk("t1_out_ch", 64'(out_ch_s[0]), 64'h2);
    chk("t1_out_last", 64'(out_last_s[0]), 64'h1);

    // Three-beat packet on ch1, sel moves to 3 mid-packet, ch3 waiting.
    step();
    sel_s[0] = 2'd1; in_valid_s[0] = 4'b1010; in_last_s[0] = 4'b1000;
    set_ch(0, 1, 8'h11); set_ch(0, 3, 8'h99);
    @(negedge clk);
    chk("t2_first_ready", 64'(in_ready_s[0]), 64'h2);
    step();
    sel_s[0] = 2'd3; set_ch(0, 1, 8'h22);
    @(negedge clk);
    chk("t2_b1_data", 64'(out_data_s[0]), 64'h11);
    chk("t2_b1_ch", 64'(out_ch_s[0]), 64'h1);
    chk("t2_lock_ready", 64'(in_ready_s[0]), 64'h2);
    step();
    set_ch(0, 1, 8'h33); in_last_s[0] = 4'b1010;
    @(negedge clk);
    chk("t2_b2_data", 64'(out_data_s[0]), 64'h22);
    step();
    in_valid_s[0] = 4'b1000;
    @(negedge clk);
    chk("t2_b3_data", 64'(out_data_s[0]), 64'h33);
    chk("t2_b3_ch", 64'(out_ch_s[0]), 64'h1);
    chk("t2_ch3_ready", 64'(in_ready_s[0]), 64'h8);
    step();
    in_valid_s[0] = '0;
    @(negedge clk);
    chk("t2_ch3_data", 64'(out_data_s[0]), 64'h99);
    chk("t2_ch3_ch", 64'(out_ch_s[0]), 64'h3);

    // Backpressure for five cycles on a held 0x55 beat.
    step();
    sel_s[0] = 2'd0; in_valid_s[0] = 4'b0001; in_last_s[0] = 4'b0001; set_ch(0, 0, 8'h55);
    step();
    out_ready_s[0] = 1'b0; set_ch(0, 0, 8'h66);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_data", 64'(out_data_s[0]), 64'h55);
      chk("t4_hold_ready", 64'(in_ready_s[0]), 64'h0);
      @(posedge clk);
    end
    #1 out_ready_s[0] = 1'b1;
    @(negedge clk);
    chk("t4_resume_ready", 64'(in_ready_s[0]), 64'h1);
    step();
    in_valid_s[0] = '0;
    @(negedge clk);
    chk("t4_next_data", 64'(out_data_s[0]), 64'h66);
    step();
    @(negedge clk);
    chk("t4_drain_valid", 64'(out_valid_s[0]), 64'h0);
    chk("t4_drain_data", 64'(out_data_s[0]), 64'h66);

    // Reset in the middle of a ch2 packet on the round-robin instance.
    step();
    in_valid_s[1] = 4'b0100; in_last_s[1] = 4'b0000; set_ch(1, 2, 8'h70);
    step();
    set_ch(1, 2, 8'h71);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("t5_async_valid", 64'(out_valid_s[1]), 64'h0);
    chk("t5_rst_ready", 64'(in_ready_s[1]), 64'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    in_valid_s[1] = 4'b1111; in_last_s[1] = 4'b1111;
    step();
    in_valid_s[1] = '0;
    @(negedge clk);
    chk("t5_after_rst_ch", 64'(out_ch_s[1]), 64'h0);
    chk("t5_after_rst_valid", 64'(out_valid_s[1]), 64'h1);

`ifdef STREAM_MUX_PKT_CNT_EN
    // Counter wrap: 65537 single-beat packets on ch0.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    step();
    quiet = 1'b1;
    sel_s[0] = 2'd0; in_valid_s[0] = 4'b0001; in_last_s[0] = 4'b0001;
    repeat (65537) @(posedge clk);
    #1 in_valid_s[0] = '0;
    @(negedge clk);
    chk("cnt_ch0", 64'(pkt_cnt_s[0][15:0]), 64'h1);
    chk("cnt_others", 64'(pkt_cnt_s[0][63:16]), 64'h0);
    quiet = 1'b0;
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel stream multiplexer; successor to the 2:1 combinational mux.
- Adds valid/ready handshake per channel and a registered output stage.
- Grant is packet-locked: a channel keeps the output until its last beat transfers.
- Channel choice is either an external select or round-robin; sits between multiple producers and one consumer on the datapath.

Parameters:
- WIDTH, 8, data width per channel.
- N_CH, 4, number of input channels (>=2).
- ARB_MODE, 0, 0 = external select (sel port), 1 = round-robin.
- SEL_W, $clog2(N_CH), derived; width of sel and out_ch.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel beat valid.
- in_last  input  N_CH  per-channel last beat of packet.
- in_ready  output  N_CH  per-channel beat accepted.
- sel  input  SEL_W  requested channel; used only when ARB_MODE=0.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_last  output  1  registered last.
- out_ch  output  SEL_W  source channel of the current output beat.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (async assert, sync deassert handled upstream): out_valid=0, out_last=0, out_data=0, out_ch=0, state=IDLE, rr_ptr=N_CH-1 (so channel 0 wins first). in_ready=0 during reset.
- Transfer on an input: in_valid[i] && in_ready[i] at a rising edge. Transfer on the output: out_valid && out_ready.
- load_ok = !out_valid || out_ready. The output register loads whenever load_ok and the granted channel transfers.
- in_ready[i] = (i == grant) && grant_valid && load_ok. Never more than one bit set.
- State IDLE:
  - ARB_MODE=0: grant=sel; grant_valid = in_valid[sel].
  - ARB_MODE=1: grant = first i with in_valid[i], searching from rr_ptr+1 upward with modulo N_CH wrap; grant_valid = |in_valid.
  - Grant is combinational, so the first beat transfers in the same cycle it wins arbitration; no bubble.
  - First beat with in_last=1: stay IDLE (single-beat packet).
  - First beat with in_last=0: go LOCKED, register locked_ch=grant.
- State LOCKED:
  - grant = locked_ch; sel and other channels' valids are ignored.
  - The beat with in_last=1 transfers: go IDLE.
- rr_ptr updates to the granted channel when a last beat transfers, in either state.
- Latency: a beat accepted at edge k is on out_* after edge k. Sustained throughput is 1 beat/clk while out_ready=1.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready=0 and out_* is held stable.
- When out_ready=1 and no new beat is loaded, out_valid falls to 0; data and last hold their last value.
- sel changing mid-packet has no effect until the return to IDLE.
- An in_valid drop mid-packet holds the lock with no timeout.
- Reset mid-packet discards the in-flight beat and the lock immediately.

Optional Feature:
- Macro: STREAM_MUX_PKT_CNT_EN.
- Defined: adds output pkt_cnt [N_CH*16].
  - Per-channel counter increments when that channel's last beat transfers at the input.
  - Counter wraps 0xFFFF->0x0000; reset value 0.
- Undefined: the port and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package stream_mux_pkg:
  - typedef enum logic {IDLE, LOCKED} state_e.
  - localparam CNT_W = 16.
  - function rr_next(req, ptr) returning the next index.
- Sub-module rr_arbiter (N_CH parameter):
  - Inputs req and ptr; outputs gnt_idx and gnt_vld.
  - Combinational; used only when ARB_MODE=1, with ptr register kept in the parent.

Test Plan (WIDTH=8, N_CH=4):
- ARB_MODE=0, sel=2, in_valid=4'b0100, data 0xAA, last=1, out_ready=1 -> in_ready=4'b0100 same cycle; next cycle out_data=0xAA, out_ch=2, out_valid=1, out_last=1.
- ARB_MODE=0, 3-beat packet 0x11/0x22/0x33 on ch1, sel switched to 3 after beat 1 -> all three beats out with out_ch=1; ch3 granted only after 0x33 transfers.
- ARB_MODE=1, all channels valid with single-beat packets, out_ready=1 -> out_ch sequence 0,1,2,3,0; one beat/clk.
- out_ready held 0 for 5 cycles with out_valid=1, data 0x55 -> out_data stable at 0x55, in_ready=0 throughout; resumes with no lost or duplicated beat.
- rst_n pulsed low mid-packet on ch2 -> out_valid=0 asynchronously; after release, ARB_MODE=1 with all valid grants ch0.
- STREAM_MUX_PKT_CNT_EN defined: 65537 single-beat packets on ch0 -> pkt_cnt[15:0]=1, other counters 0.
